// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the multi-channel debouncer:
//   - state_e   : per-channel FSM state encoding (2 bits, all codes used)
//   - cnt_fits  : elaboration-time check that STABLE_CNT-1 fits in CNT_W bits
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    S_ZERO  = 2'b00,  // stable low,  dout = 0
    S_WAIT1 = 2'b01,  // qualifying a rise, dout = 0
    S_ONE   = 2'b10,  // stable high, dout = 1
    S_WAIT0 = 2'b11   // qualifying a fall, dout = 1
  } state_e;

  // True when 1 <= stable_cnt <= 2^cnt_w - 1, so the counter never has to
  // hold a value it cannot represent and never wraps.
  function automatic bit cnt_fits(input int cnt_w, input int stable_cnt);
    longint max_v;
    bit     ok;
    if ((cnt_w < 32'sd1) || (cnt_w > 32'sd62)) begin
      ok = 1'b0;
    end else begin
      max_v = (64'sd1 <<< cnt_w) - 64'sd1;
      ok    = (stable_cnt >= 32'sd1) && (longint'(stable_cnt) <= max_v);
    end
    return ok;
  endfunction

endpackage

// File: rtl/debounce_multi_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
// One debouncer channel: input synchroniser, 4-state FSM, stability counter
// and registered dout / rise / fall.
// Ports:
//   clk_i   in   system clock (rising edge)
//   rst_i   in   asynchronous active-high reset
//   tick_i  in   count enable for the stability counter
//   din_i   in   raw asynchronous input
//   dout_o  out  debounced level (registered)
//   rise_o  out  1-cycle strobe on dout 0->1 (registered)
//   fall_o  out  1-cycle strobe on dout 1->0 (registered)
// -----------------------------------------------------------------------------
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int   CNT_W       = 16,
  parameter int   STABLE_CNT  = 1000,
  parameter int   SYNC_STAGES = 2,
  parameter logic D_INIT      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic din_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   din_s;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   dout_q;
  logic                   rise_q;
  logic                   fall_q;

  // Synchroniser chain; resets to the channel's initial level so that no
  // spurious edge is seen right after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{D_INIT}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
    end
  end

  assign din_s = sync_q[SYNC_STAGES-1];

  // Debounce FSM with counter and registered outputs. In the WAIT states the
  // abort test comes first, so a reverting input beats a completing count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= D_INIT ? S_ONE : S_ZERO;
      cnt_q   <= '0;
      dout_q  <= D_INIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        S_ZERO: begin
          if (din_s) begin
            state_q <= S_WAIT1;
            cnt_q   <= '0;
          end else begin
            state_q <= S_ZERO;
          end
        end
        S_ONE: begin
          if (!din_s) begin
            state_q <= S_WAIT0;
            cnt_q   <= '0;
          end else begin
            state_q <= S_ONE;
          end
        end
        S_WAIT1: begin
          if (!din_s) begin
            state_q <= S_ZERO;
          end else if (tick_i && (cnt_q == CNT_LAST)) begin
            state_q <= S_ONE;
            dout_q  <= 1'b1;
            rise_q  <= 1'b1;
          end else if (tick_i) begin
            cnt_q <= cnt_q + CNT_ONE;
          end else begin
            state_q <= S_WAIT1;
          end
        end
        S_WAIT0: begin
          if (din_s) begin
            state_q <= S_ONE;
          end else if (tick_i && (cnt_q == CNT_LAST)) begin
            state_q <= S_ZERO;
            dout_q  <= 1'b0;
            fall_q  <= 1'b1;
          end else if (tick_i) begin
            cnt_q <= cnt_q + CNT_ONE;
          end else begin
            state_q <= S_WAIT0;
          end
        end
        default: begin
          // Unreachable with a 2-bit fully-used encoding; recover to low.
          state_q <= S_ZERO;
          cnt_q   <= '0;
          dout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout_o = dout_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
// NCH independent debouncer channels sharing clock, reset and tick enable,
// plus a summary flag raised whenever any channel strobes.
// Ports:
//   clk         in   system clock (rising edge)
//   rst         in   asynchronous active-high reset
//   tick        in   shared count enable (tie high for per-clock counting)
//   din         in   [NCH] raw asynchronous inputs
//   dout        out  [NCH] debounced levels (registered)
//   rise        out  [NCH] 1-cycle strobes on 0->1
//   fall        out  [NCH] 1-cycle strobes on 1->0
//   any_change  out  OR of all rise|fall bits
// -----------------------------------------------------------------------------
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int             NCH         = 4,
  parameter int             CNT_W       = 16,
  parameter int             STABLE_CNT  = 1000,
  parameter int             SYNC_STAGES = 2,
  parameter logic [NCH-1:0] D_INIT      = {NCH{1'b0}}
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic [NCH-1:0] din,
  output logic [NCH-1:0] dout,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic           any_change
);

  // Parameter sanity is resolved at elaboration, never in hardware.
  if (!cnt_fits(CNT_W, STABLE_CNT)) begin : g_cnt_chk
    $error("debounce_multi: STABLE_CNT=%0d does not fit in CNT_W=%0d bits", STABLE_CNT, CNT_W);
  end
  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("debounce_multi: SYNC_STAGES=%0d, at least 2 required", SYNC_STAGES);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    debounce_ch #(
      .CNT_W       (CNT_W),
      .STABLE_CNT  (STABLE_CNT),
      .SYNC_STAGES (SYNC_STAGES),
      .D_INIT      (D_INIT[i])
    ) u_ch (
      .clk_i  (clk),
      .rst_i  (rst),
      .tick_i (tick),
      .din_i  (din[i]),
      .dout_o (dout[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

  // Strobes are registered, so this OR is glitch-free at the clock edge.
  assign any_change = |(rise | fall);

endmodule

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
// Two instances: dut_a (STABLE_CNT=4, tick tied high) and dut_b (STABLE_CNT=3,
// tick high on every 4th edge). Both have NCH=4, SYNC_STAGES=2, D_INIT=0101.
// Expected outputs are queued when stimulus is applied and popped one per
// clock, 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_a;
  logic       tick_b;
  logic [3:0] din_a, din_b;
  logic [3:0] dout_a, rise_a, fall_a;
  logic [3:0] dout_b, rise_b, fall_b;
  logic       any_a, any_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .NCH(4), .CNT_W(16), .STABLE_CNT(4), .SYNC_STAGES(2), .D_INIT(4'b0101)
  ) dut_a (
    .clk(clk), .rst(rst), .tick(tick_a), .din(din_a),
    .dout(dout_a), .rise(rise_a), .fall(fall_a), .any_change(any_a)
  );

  debounce_multi #(
    .NCH(4), .CNT_W(16), .STABLE_CNT(3), .SYNC_STAGES(2), .D_INIT(4'b0101)
  ) dut_b (
    .clk(clk), .rst(rst), .tick(tick_b), .din(din_b),
    .dout(dout_b), .rise(rise_b), .fall(fall_b), .any_change(any_b)
  );

  typedef struct {
    string      tag;
    bit         use_b;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
  } exp_t;

  exp_t sbq[$];

  task automatic push_exp(input string tag, input bit use_b,
                          input logic [3:0] d, input logic [3:0] r, input logic [3:0] f);
    exp_t e;
    e.tag   = tag;
    e.use_b = use_b;
    e.dout  = d;
    e.rise  = r;
    e.fall  = f;
    e.any   = |(r | f);
    sbq.push_back(e);
  endtask

  task automatic plan_quiet(input string tag, input bit use_b, input int n, input logic [3:0] d);
    repeat (n) push_exp(tag, use_b, d, 4'b0000, 4'b0000);
  endtask

  // n_quiet cycles at d_old, one strobe cycle at d_new, one quiet cycle after.
  task automatic plan_edge(input string tag, input bit use_b, input int n_quiet,
                           input logic [3:0] d_old, input logic [3:0] d_new,
                           input logic [3:0] r, input logic [3:0] f);
    plan_quiet(tag, use_b, n_quiet, d_old);
    push_exp(tag, use_b, d_new, r, f);
    push_exp(tag, use_b, d_new, 4'b0000, 4'b0000);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [12:0] act, exv;
    checks++;
    assert (sbq.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 queued entries, expected at least 1");
    end
    if (sbq.size() != 0) begin
      e   = sbq.pop_front();
      act = e.use_b ? {dout_b, rise_b, fall_b, any_b} : {dout_a, rise_a, fall_a, any_a};
      exv = {e.dout, e.rise, e.fall, e.any};
      assert (act === exv) else begin
        errors++;
        $error("FAIL %s: observed dout/rise/fall/any=%b expected %b (cycle %0d, dut_%s)",
               e.tag, act, exv, cyc, e.use_b ? "b" : "a");
      end
    end
  endtask

  // Advance one rising edge; tick_b is high during edges whose number is a multiple of 4.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    tick_b = (((cyc + 1) % 4) == 0);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      check_out();
    end
  endtask

  task automatic align4();
    while ((cyc % 4) != 0) step();
  endtask

  // Asynchronous reset pulse between edges; outputs must reach D_INIT before any edge.
  task automatic pulse_reset(input string tag, input logic [3:0] din_hold);
    #2;
    rst = 1'b1;
    #1;
    din_a = din_hold;
    push_exp(tag, 1'b0, 4'b0101, 4'b0000, 4'b0000);
    push_exp(tag, 1'b1, 4'b0101, 4'b0000, 4'b0000);
    check_out();
    check_out();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    tick_a = 1'b1;
    tick_b = 1'b0;
    din_a  = 4'b0101;
    din_b  = 4'b0101;
    #12;
    push_exp("reset_a", 1'b0, 4'b0101, 4'b0000, 4'b0000);
    push_exp("reset_b", 1'b1, 4'b0101, 4'b0000, 4'b0000);
    check_out();
    check_out();
    rst = 1'b0;

    plan_quiet("post_reset", 1'b0, 3, 4'b0101);
    run(3);

    // Channel 0 falls, then a clean rise: 7 edges from din change to strobe.
    din_a = 4'b0100;
    plan_edge("fall_ch0", 1'b0, 6, 4'b0101, 4'b0100, 4'b0000, 4'b0001);
    run(8);
    din_a = 4'b0101;
    plan_edge("clean_rise", 1'b0, 6, 4'b0100, 4'b0101, 4'b0001, 4'b0000);
    run(8);

    // Channel 1 bounces with 2-cycle periods and settles low.
    plan_quiet("bounce", 1'b0, 18, 4'b0101);
    din_a = 4'b0111; run(2);
    din_a = 4'b0101; run(2);
    din_a = 4'b0111; run(2);
    din_a = 4'b0101; run(12);

    // Channel 1 high for 4 edges: synchronised input reverts exactly when
    // cnt reaches STABLE_CNT-1 with tick high, so the abort must win.
    plan_quiet("abort_prio", 1'b0, 12, 4'b0101);
    din_a = 4'b0111; run(4);
    din_a = 4'b0101; run(8);

    // Channels 0 and 3 rise together.
    din_a = 4'b0100;
    plan_edge("fall_ch0_b", 1'b0, 6, 4'b0101, 4'b0100, 4'b0000, 4'b0001);
    run(8);
    din_a = 4'b1101;
    plan_edge("multi_rise", 1'b0, 6, 4'b0100, 4'b1101, 4'b1001, 4'b0000);
    run(8);

    // Mid-simulation reset from dout=1101 back to D_INIT, then no strobes.
    pulse_reset("async_reset", 4'b0101);
    plan_quiet("post_reset2", 1'b0, 10, 4'b0101);
    run(10);

    // Reset while channels 1 and 3 are in WAIT1; the change restarts from scratch.
    din_a = 4'b1111;
    plan_quiet("pre_rst_wait", 1'b0, 4, 4'b0101);
    run(4);
    pulse_reset("rst_in_wait", 4'b1111);
    plan_edge("rst_wait_restart", 1'b0, 6, 4'b0101, 4'b1111, 4'b1010, 4'b0000);
    run(8);

    // Tick gating on dut_b channel 2: WAIT0 at k+3, ticks at k+4,k+8,k+12.
    align4();
    din_b = 4'b0001;
    plan_edge("tick_fall", 1'b1, 11, 4'b0101, 4'b0001, 4'b0000, 4'b0100);
    run(13);

    // Glitch between ticks: abort at k+7, WAIT1 again at k+8, rise at k+20.
    align4();
    plan_edge("tick_glitch", 1'b1, 19, 4'b0001, 4'b0101, 4'b0100, 4'b0000);
    din_b = 4'b0101; run(4);
    din_b = 4'b0001; run(1);
    din_b = 4'b0101; run(16);

    checks++;
    assert (sbq.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d leftover entries, expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
